// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding and pin idle levels.
package spi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOW  = 3'd1,
      ST_HIGH = 3'd2,
      ST_TAIL = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period timer for the SPI master: a down-counter that is reloaded on
// every sck edge (and at transfer start) and flags the last cycle of a
// DIV-cycle phase with tick_o.
module spi_master_clkgen #(
   parameter int DIV = 4
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int             CW     = $clog2(DIV + 1);
   localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: reload wins over counting; the counter parks at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = RELOAD;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   // Counter register.
   always_ff @(posedge clock_i) begin
      if (reset_i)
         cnt_q <= RELOAD;
      else
         cnt_q <= cnt_d;
   end

   assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master, MSB first. One command per transfer
// over a valid/ready port; received word returned over a valid/ready port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | ready for a command; pins at idle levels
//   LOW     | sck low for DIV cycles; mosi holds the current bit
//   HIGH    | sck high for DIV cycles; miso sampled on the way back down
//   TAIL    | all bits done, ss_n held low DIV more cycles for slave hold time
//   RESP    | rsp_valid high until the response is taken
module spi_master
   import spi_master_pkg::*;
#(
   parameter int DIV     = 4,
   parameter int MAX_LEN = 16,
   parameter int SS_W    = 8
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   input  logic [MAX_LEN-1:0]         cmd_data_i,
   input  logic [$clog2(MAX_LEN):0]   cmd_len_i,
   input  logic [$clog2(SS_W)-1:0]    cmd_ss_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [MAX_LEN-1:0]         rsp_data_o,
   output logic                       sck_o,
   output logic [SS_W-1:0]            ss_n_o,
   output logic                       mosi_o,
   input  logic                       miso_i
);

   localparam int LW = $clog2(MAX_LEN) + 1;

   state_e              state_q, state_d;
   logic [MAX_LEN-1:0]  tx_q, tx_d;
   logic [MAX_LEN-1:0]  rx_q, rx_d;
   logic [LW-1:0]       bits_q, bits_d;
   logic [SS_W-1:0]     ss_n_q, ss_n_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;

   logic [LW-1:0]       len_eff;
   logic [MAX_LEN-1:0]  tx_aligned;
   logic [SS_W-1:0]     ss_sel;
   logic                accept;
   logic                tick;
   logic                clk_en;

   assign accept = (state_q == ST_IDLE) && cmd_valid_i;
   assign clk_en = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_TAIL);

   spi_master_clkgen #(
      .DIV (DIV)
   ) u_clkgen (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (accept || tick),
      .en_i    (clk_en),
      .tick_o  (tick)
   );

   // Command decode: clamp the length, left-align tx so the first bit is the MSB,
   // and one-hot the slave index (an out-of-range index selects nothing).
   always_comb begin
      len_eff = cmd_len_i;
      if ((cmd_len_i == '0) || (cmd_len_i > LW'(MAX_LEN)))
         len_eff = LW'(MAX_LEN);
      tx_aligned = cmd_data_i << (LW'(MAX_LEN) - len_eff);
      ss_sel = '0;
      for (int i = 0; i < SS_W; i++)
         ss_sel[i] = (int'(cmd_ss_i) == i);
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bits_d  = bits_q;
      ss_n_d  = ss_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               tx_d    = tx_aligned;
               rx_d    = '0;
               bits_d  = len_eff;
               ss_n_d  = ~ss_sel;
               mosi_d  = tx_aligned[MAX_LEN-1];
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (tick) begin
               sck_d   = 1'b1;
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (tick) begin
               sck_d = SCK_IDLE;
               rx_d  = {rx_q[MAX_LEN-2:0], miso_i};
               if (bits_q != '0)
                  bits_d = bits_q - LW'(1);
               if (bits_q > LW'(1)) begin
                  tx_d    = tx_q << 1;
                  mosi_d  = tx_q[MAX_LEN-2];
                  state_d = ST_LOW;
               end else begin
                  state_d = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            if (tick) begin
               ss_n_d  = '1;
               mosi_d  = MOSI_IDLE;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any transfer in flight.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         bits_q  <= '0;
         ss_n_q  <= '1;
         sck_q   <= SCK_IDLE;
         mosi_q  <= MOSI_IDLE;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bits_q  <= bits_d;
         ss_n_q  <= ss_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
      end
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_data_o  = rx_q;
   assign sck_o       = sck_q;
   assign ss_n_o      = ss_n_q;
   assign mosi_o      = mosi_q;

endmodule
